rt_ctx_switch_ctrl: RTL and testbench
=====================================

Name: rt_ctx_switch_ctrl

Overview:
Context save/restore sequencer for the RT-Core register file (8x32, 2R/1W, asynchronous read).
- On an interrupt-entry save request: walks R0..R7 through one read port and stores each register to a memory frame.
- On a return request: reloads R0..R7 from the frame through the write port.
- While busy it owns the register-file ports and stalls the pipeline; an external mux selects between controller and pipeline using rf_own.

Parameters:
NUM_REGS, 8, number of registers saved/restored (R0..NUM_REGS-1)
RIDX_W, 3, register index width (clog2 NUM_REGS)
DATA_W, 32, register and memory word width

Ports:
clk  input  1  core clock
rst_n  input  1  reset, synchronous, active-low
save_req  input  1  start context save (sampled in IDLE only)
restore_req  input  1  start context restore (sampled in IDLE only)
base_addr  input  32  frame base byte address, latched at request accept
busy  output  1  high from the first cycle after accept through the DONE cycle
done  output  1  one-cycle pulse in DONE
rf_own  output  1  equals busy; steers the regfile port mux; also serves as pipeline stall
rf_raddr  output  RIDX_W  regfile read-port address
rf_rdata  input  DATA_W  regfile read data (combinational from rf_raddr)
rf_we  output  1  regfile write enable
rf_waddr  output  RIDX_W  regfile write address
rf_wdata  output  DATA_W  regfile write data
mem_req  output  1  memory request valid
mem_we  output  1  1 = store, 0 = load
mem_addr  output  32  word-aligned byte address
mem_wdata  output  DATA_W  store data
mem_gnt  input  1  memory accepts the request this cycle
mem_rvalid  input  1  load data valid
mem_rdata  input  DATA_W  load data

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous, active-low.
- Reset state: IDLE, idx=0, base=0. All outputs 0 (busy, done, rf_own, rf_we, mem_req, mem_we, all address/data buses).
- States: IDLE, SAVE, LOAD_REQ, LOAD_WAIT, DONE.
- IDLE:
  - save_req=1 -> SAVE; restore_req=1 -> LOAD_REQ. save_req wins when both are high.
  - On accept: base latched as {base_addr[31:2],2'b00}; idx cleared to 0.
  - Requests are ignored in every non-IDLE state; no queuing.
- SAVE:
  - mem_req=1, mem_we=1, rf_raddr=idx, mem_wdata=rf_rdata (combinational).
  - mem_addr = base + 4*idx, modulo 2^32 (wrap allowed, no error).
  - Signals are held stable until mem_gnt. On mem_gnt: idx++; if idx==NUM_REGS-1 -> DONE.
- LOAD_REQ:
  - mem_req=1, mem_we=0, same address rule. On mem_gnt -> LOAD_WAIT.
- LOAD_WAIT:
  - mem_req=0. On mem_rvalid: rf_we=1, rf_waddr=idx, rf_wdata=mem_rdata in the same cycle (combinational).
  - After that write: if idx==NUM_REGS-1 -> DONE, else idx++ and -> LOAD_REQ.
  - One outstanding load only. mem_rvalid outside LOAD_WAIT is ignored.
- DONE: done=1, busy=1 for one cycle, then -> IDLE.
- rf_we=0 everywhere except LOAD_WAIT with mem_rvalid. Address/data outputs are 0 when not driven by the active state.
- Latency, save with mem_gnt tied 1: request sampled at edge N; SAVE occupies cycles N+1..N+8; done at N+9.
- Latency, restore with gnt=1 and rvalid the cycle after gnt: 2 cycles per register; done at N+17.
- Reset mid-operation: return to IDLE at the next edge. No rollback; registers already restored keep their new values. Partially written memory is left as is.
- Last register's write coincides with its DONE-transition edge; no extra cycle is inserted.

Decomposition:
- rt_core_pkg: ctx_state_e enum (IDLE, SAVE, LOAD_REQ, LOAD_WAIT, DONE) and CTX_WORD_BYTES=4.
- No sub-module: a single FSM plus index and base registers. The controller/pipeline port mux lives in the core top, not in this block.

Test Plan:
- Save, gnt=1: regs Rk=32'hA0+k, base 32'h1000 -> stores 1000..101C with data A0..A7, one per cycle; done at N+9; rf_we never asserted.
- Save with backpressure: gnt low for 3 cycles on idx 2 -> mem_addr 1008 and mem_wdata A2 held stable all 3 cycles; total 12 cycles to done.
- Restore, rvalid 1 cycle after gnt, mem[1000+4k]=32'h5500+k -> Rk=5500+k after done at N+17; verify through both regfile read ports.
- save_req and restore_req both high in IDLE -> save performed. Any request while busy -> ignored; no second done pulse.
- base_addr 32'hFFFF_FFF3 -> latched FFFF_FFF0; addresses FFFF_FFF0, FFFF_FFF4, FFFF_FFF8, FFFF_FFFC, 0000_0000, ... (wrap).
- rst_n low during restore after 3 registers -> IDLE next edge, all outputs 0; R0..R2 keep restored values, R3..R7 are reset by the regfile reset.

Source files
------------

// File: rtl/rt_core_pkg.sv
// rt_core_pkg
// Shared types and constants for the RT-Core context switch controller.
//   ctx_state_e    : sequencer states (IDLE, SAVE, LOAD_REQ, LOAD_WAIT, DONE)
//   CTX_WORD_BYTES : byte stride between consecutive frame words
//   frame_addr()   : base + stride*idx, wrapping modulo 2^32
package rt_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    LOAD_REQ,
    LOAD_WAIT,
    DONE
  } ctx_state_e;

  localparam int unsigned CTX_WORD_BYTES = 4;

  // Plain 32-bit addition, so a frame that runs past the top of the
  // address space simply wraps to address 0.
  function automatic logic [31:0] frame_addr(input logic [31:0] base,
                                             input logic [31:0] idx);
    return base + idx * 32'(CTX_WORD_BYTES);
  endfunction

endpackage

// File: rtl/rt_ctx_switch_ctrl.sv
// rt_ctx_switch_ctrl
// Context save/restore sequencer for the RT-Core register file.
// A save walks R0..R(NUM_REGS-1) through the regfile read port and stores
// each one into a word-aligned memory frame. A restore loads the frame
// back through the regfile write port, one outstanding load at a time.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   save_req, restore_req start requests, only looked at in IDLE (save wins)
//   base_addr             frame base byte address, latched on accept
//   busy, rf_own          high while the sequencer owns the regfile ports
//   done                  one-cycle completion pulse
//   rf_raddr, rf_rdata    regfile read port (rf_rdata is combinational)
//   rf_we/waddr/wdata     regfile write port
//   mem_req/we/addr/wdata memory request channel, held until mem_gnt
//   mem_gnt               memory accepts the current request
//   mem_rvalid, mem_rdata load response
module rt_ctx_switch_ctrl
  import rt_core_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int RIDX_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [31:0]       base_addr,
  output logic              busy,
  output logic              done,
  output logic              rf_own,
  output logic [RIDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_REGS - 1);

  ctx_state_e        state_q, state_d;
  logic [RIDX_W-1:0] idx_q, idx_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       cur_addr;

  assign cur_addr = frame_addr(base_q, 32'(idx_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  // All outputs are decoded from the current state so that every bus
  // reads as zero whenever the active state is not driving it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    busy      = 1'b0;
    done      = 1'b0;
    rf_raddr  = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (save_req || restore_req) begin
          state_d = save_req ? SAVE : LOAD_REQ;
          idx_d   = '0;
          // Force word alignment by dropping the two byte-offset bits.
          base_d  = base_addr & ~32'h3;
        end
      end

      SAVE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        rf_raddr  = idx_q;
        mem_wdata = rf_rdata;
        mem_addr  = cur_addr;
        if (mem_gnt) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end

      LOAD_REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = cur_addr;
        if (mem_gnt) begin
          state_d = LOAD_WAIT;
        end
      end

      LOAD_WAIT: begin
        busy = 1'b1;
        // The load data goes straight to the write port in the same cycle,
        // so the last register lands on the edge that enters DONE.
        if (mem_rvalid) begin
          rf_we    = 1'b1;
          rf_waddr = idx_q;
          rf_wdata = mem_rdata;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD_REQ;
          end
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rf_own = busy;

endmodule

// File: tb/tb_rt_ctx_switch_ctrl.sv
// tb_rt_ctx_switch_ctrl
// Directed bench for rt_ctx_switch_ctrl. It hosts an 8x32 register file
// with two asynchronous read ports and one write port, muxed between the
// controller and a "pipeline" driven from the bench via rf_own. Memory
// responses are driven cycle by cycle from each scenario task.
module tb_rt_ctx_switch_ctrl;

  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        save_req, restore_req;
  logic [31:0] base_addr;
  logic        busy, done, rf_own;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_we;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Bench-side pipeline access to the register file.
  logic        rf_clear;
  logic        pipe_we;
  logic [2:0]  pipe_waddr, pipe_raddr_a, pipe_raddr_b;
  logic [31:0] pipe_wdata, rf_rdata_b;

  logic [31:0] rf [NR];
  logic [2:0]  mux_raddr_a, mux_waddr;
  logic        mux_we;
  logic [31:0] mux_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mux_raddr_a = rf_own ? rf_raddr : pipe_raddr_a;
  assign mux_we      = rf_own ? rf_we    : pipe_we;
  assign mux_waddr   = rf_own ? rf_waddr : pipe_waddr;
  assign mux_wdata   = rf_own ? rf_wdata : pipe_wdata;
  assign rf_rdata    = rf[mux_raddr_a];
  assign rf_rdata_b  = rf[pipe_raddr_b];

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < NR; i++) rf[i] <= 32'h0;
    end else if (mux_we) begin
      rf[mux_waddr] <= mux_wdata;
    end
  end

  rt_ctx_switch_ctrl #(.NUM_REGS(8), .RIDX_W(3), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .save_req   (save_req),
    .restore_req(restore_req),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .rf_own     (rf_own),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // Packed view of every controller output, rf_own sitting next to busy.
  logic [107:0] obs;
  assign obs = {busy, done, rf_own, mem_req, mem_we, rf_we,
                rf_raddr, rf_waddr, mem_addr, mem_wdata, rf_wdata};

  function automatic logic [107:0] ev(input logic b, input logic d,
                                      input logic rq, input logic we,
                                      input logic rfwe,
                                      input logic [2:0] ra, input logic [2:0] wa,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [31:0] rwd);
    return {b, d, b, rq, we, rfwe, ra, wa, addr, wd, rwd};
  endfunction

  task automatic preload(input logic [31:0] first);
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      pipe_we    = 1'b1;
      pipe_waddr = 3'(k);
      pipe_wdata = first + 32'(k);
    end
    @(negedge clk);
    pipe_we = 1'b0;
  endtask

  // Raise the requests at a negedge; the following posedge accepts them.
  task automatic start(input logic s, input logic r, input logic [31:0] base);
    @(negedge clk);
    save_req    = s;
    restore_req = r;
    base_addr   = base;
  endtask

  task automatic test_reset();
    logic [107:0] e;
    rst_n = 1'b0;
    save_req = 1'b1;
    restore_req = 1'b1;
    base_addr = 32'h1234_5678;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    rf_clear = 1'b0; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    pipe_raddr_a = '0; pipe_raddr_b = '0;
    repeat (2) @(negedge clk);
    #1;
    e = '0;
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    save_req = 1'b0;
    restore_req = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_save_basic();
    logic [107:0] e;
    preload(32'hA0);
    start(1'b1, 1'b0, 32'h1000);
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      save_req = 1'b0;
      mem_gnt  = 1'b1;
      #1;
      e = ev(1, 0, 1, 1, 0, 3'(k), 3'd0, 32'h1000 + 32'(4*k), 32'hA0 + 32'(k), 32'h0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL save_store k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    @(negedge clk);
    #1;
    e = ev(1, 1, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL save_done_n9 got=%h exp=%h", obs, e);
    end
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    total++;
    if (obs !== 108'h0) begin
      bad++;
      $display("[TB] FAIL save_back_idle got=%h exp=0", obs);
    end
  endtask

  task automatic test_save_backpressure();
    logic [107:0] e;
    int  idx_tab [11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    bit  gnt_tab [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    start(1'b1, 1'b0, 32'h1000);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      save_req = 1'b0;
      mem_gnt  = gnt_tab[c];
      #1;
      e = ev(1, 0, 1, 1, 0, 3'(idx_tab[c]), 3'd0, 32'h1000 + 32'(4*idx_tab[c]),
             32'hA0 + 32'(idx_tab[c]), 32'h0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL bp_store c=%0d got=%h exp=%h", c, obs, e);
      end
    end
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    e = ev(1, 1, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL bp_done_n12 got=%h exp=%h", obs, e);
    end
  endtask

  // Restores up to 'count' registers; junk rvalid during LOAD_REQ must be ignored.
  task automatic restore_regs(input int count, input string tag);
    logic [107:0] e;
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      restore_req = 1'b0;
      mem_gnt     = 1'b1;
      mem_rvalid  = 1'b1;
      mem_rdata   = 32'hDEAD_BEEF;
      #1;
      e = ev(1, 0, 1, 0, 0, 3'd0, 3'd0, 32'h1000 + 32'(4*k), 32'h0, 32'h0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL %s_load_req k=%0d got=%h exp=%h", tag, k, obs, e);
      end
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5500 + 32'(k);
      #1;
      e = ev(1, 0, 0, 0, 1, 3'd0, 3'(k), 32'h0, 32'h0, 32'h5500 + 32'(k));
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL %s_load_wr k=%0d got=%h exp=%h", tag, k, obs, e);
      end
    end
  endtask

  task automatic test_restore();
    logic [107:0] e;
    start(1'b0, 1'b1, 32'h1000);
    restore_regs(NR, "rst");
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
    e = ev(1, 1, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL restore_done_n17 got=%h exp=%h", obs, e);
    end
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      pipe_raddr_a = 3'(k);
      pipe_raddr_b = 3'(NR - 1 - k);
      #1;
      total++;
      if ({rf_rdata, rf_rdata_b} !== {32'h5500 + 32'(k), 32'h5500 + 32'(NR - 1 - k)}) begin
        bad++;
        $display("[TB] FAIL restore_regval k=%0d got=%h/%h exp=%h/%h", k,
                 rf_rdata, rf_rdata_b, 32'h5500 + 32'(k), 32'h5500 + 32'(NR - 1 - k));
      end
    end
  endtask

  task automatic test_both_and_busy();
    logic [107:0] e;
    preload(32'hA0);
    start(1'b1, 1'b1, 32'h2000);
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      save_req    = (k % 2 == 0);
      restore_req = 1'b1;
      base_addr   = 32'h3000;
      mem_gnt     = 1'b1;
      #1;
      e = ev(1, 0, 1, 1, 0, 3'(k), 3'd0, 32'h2000 + 32'(4*k), 32'hA0 + 32'(k), 32'h0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL both_save k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    @(negedge clk);
    save_req = 1'b1;
    #1;
    e = ev(1, 1, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL both_done got=%h exp=%h", obs, e);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      save_req    = 1'b0;
      restore_req = 1'b0;
      #1;
      total++;
      if (obs !== 108'h0) begin
        bad++;
        $display("[TB] FAIL busy_req_ignored c=%0d got=%h exp=0", c, obs);
      end
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_wrap();
    logic [107:0] e;
    logic [31:0]  a;
    start(1'b1, 1'b0, 32'hFFFF_FFF3);
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      save_req = 1'b0;
      mem_gnt  = 1'b1;
      #1;
      a = 32'hFFFF_FFF0 + 32'(4*k);
      e = ev(1, 0, 1, 1, 0, 3'(k), 3'd0, a, 32'hA0 + 32'(k), 32'h0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("[TB] FAIL wrap_addr k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    e = ev(1, 1, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL wrap_done got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_reset_abort();
    logic [107:0] e;
    logic [31:0]  want;
    @(negedge clk);
    rf_clear = 1'b1;
    @(negedge clk);
    rf_clear = 1'b0;
    start(1'b0, 1'b1, 32'h1000);
    restore_regs(3, "abort");
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    rst_n      = 1'b0;
    #1;
    e = ev(1, 0, 1, 0, 0, 3'd0, 3'd0, 32'h100C, 32'h0, 32'h0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("[TB] FAIL abort_sync_hold got=%h exp=%h", obs, e);
    end
    @(negedge clk);
    #1;
    total++;
    if (obs !== 108'h0) begin
      bad++;
      $display("[TB] FAIL abort_idle got=%h exp=0", obs);
    end
    rst_n = 1'b1;
    for (int k = 0; k < NR; k++) begin
      pipe_raddr_a = 3'(k);
      #1;
      want = (k < 3) ? 32'h5500 + 32'(k) : 32'h0;
      total++;
      if (rf_rdata !== want) begin
        bad++;
        $display("[TB] FAIL abort_regval k=%0d got=%h exp=%h", k, rf_rdata, want);
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_save_basic();
    test_save_backpressure();
    test_restore();
    test_both_and_busy();
    test_wrap();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
